note_entry_capture: RTL and testbench

- Upstream input stage for the note-sequence classifier.
- Turns a raw confirm push-button and note/tone switches into a clean single-cycle ok strobe, with nota/tom held stable alongside it.
- Counts captured notes and shows the last captured note on a 7-segment display.
- Locks out further entries once the classifier reports fim, until reset.

---
 rtl/note_entry_capture.sv | 126 ++++++++++++
 tb/tb_note_entry_capture.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/note_entry_capture.sv
// note_entry_capture: synchronizes and debounces the confirm button, then captures
// note/tone switches as a one-cycle ok strobe with a capture count, lock and 7-seg display.
module note_entry_capture #(
  parameter logic [15:0] DEB_CYCLES = 16'd50000,
  parameter logic [2:0]  MAX_NOTES  = 3'd6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_ok,
  input  logic [2:0] sw_nota,
  input  logic       sw_tom,
  input  logic       fim,
  output logic       ok,
  output logic [2:0] nota,
  output logic       tom,
  output logic [2:0] note_cnt,
  output logic       locked,
  output logic [6:0] display
);
  typedef enum logic [1:0] {REL, PRESS_PEND, PRESSED, REL_PEND} state_t;
  localparam logic [15:0] LAST = DEB_CYCLES - 16'd1;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  btn_sync_q;
  logic [2:0]  nota_s1_q, nota_s_q;
  logic        tom_s1_q, tom_s_q;
  logic        btn_s, press_evt, capture;
  logic        ok_q, ok_d, tom_q, tom_d, locked_q, locked_d;
  logic [2:0]  nota_q, nota_d, note_cnt_q, note_cnt_d;
  logic [6:0]  display_q, display_d, seg;
  assign btn_s = btn_sync_q[1];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_sync_q <= '0;
      nota_s1_q  <= '0;
      nota_s_q   <= '0;
      tom_s1_q   <= 1'b0;
      tom_s_q    <= 1'b0;
    end else begin
      btn_sync_q <= {btn_sync_q[0], btn_ok};
      nota_s1_q  <= sw_nota;
      nota_s_q   <= nota_s1_q;
      tom_s1_q   <= sw_tom;
      tom_s_q    <= tom_s1_q;
    end
  end
  // any bounce during a pending state restarts the count from scratch
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_evt = 1'b0;
    case (state_q)
      REL: if (btn_s) begin
        state_d = PRESS_PEND;
        cnt_d   = 16'd1;
      end
      PRESS_PEND: if (!btn_s) begin
        state_d = REL;
        cnt_d   = '0;
      end else if (cnt_q == LAST) begin
        state_d   = PRESSED;
        cnt_d     = '0;
        press_evt = 1'b1;
      end else cnt_d = cnt_q + 16'd1;
      PRESSED: if (!btn_s) begin
        state_d = REL_PEND;
        cnt_d   = 16'd1;
      end
      REL_PEND: if (btn_s) begin
        state_d = PRESSED;
        cnt_d   = '0;
      end else if (cnt_q == LAST) begin
        state_d = REL;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 16'd1;
    endcase
  end
  always_comb begin
    seg = 7'b1000000;
    case (nota_s_q)
      3'd1: seg = 7'b0111001;
      3'd2: seg = 7'b1011110;
      3'd3: seg = 7'b1111001;
      3'd4: seg = 7'b1110001;
      3'd5: seg = 7'b0111101;
      3'd6: seg = 7'b1110111;
      3'd7: seg = 7'b1111100;
      default: seg = 7'b1000000;
    endcase
  end
  // fim in the same cycle as a press wins: the capture is dropped
  assign capture    = press_evt && !locked_q && !fim && (note_cnt_q < MAX_NOTES);
  assign ok_d       = capture;
  assign nota_d     = capture ? nota_s_q : nota_q;
  assign tom_d      = capture ? tom_s_q : tom_q;
  assign display_d  = capture ? seg : display_q;
  assign note_cnt_d = capture ? note_cnt_q + 3'd1 : note_cnt_q;
  assign locked_d   = locked_q || fim || (capture && note_cnt_q == MAX_NOTES - 3'd1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= REL;
      cnt_q      <= '0;
      ok_q       <= 1'b0;
      nota_q     <= '0;
      tom_q      <= 1'b0;
      note_cnt_q <= '0;
      locked_q   <= 1'b0;
      display_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ok_q       <= ok_d;
      nota_q     <= nota_d;
      tom_q      <= tom_d;
      note_cnt_q <= note_cnt_d;
      locked_q   <= locked_d;
      display_q  <= display_d;
    end
  end
  assign ok       = ok_q;
  assign nota     = nota_q;
  assign tom      = tom_q;
  assign note_cnt = note_cnt_q;
  assign locked   = locked_q;
  assign display  = display_q;
endmodule

// File: tb/tb_note_entry_capture.sv
// tb_note_entry_capture: directed presses push expected captures into a queue;
// a negedge monitor pops and checks every ok strobe, including its exact arrival cycle.
module tb_note_entry_capture;
  logic       clk = 1'b0, reset = 1'b1, btn_ok = 1'b0, sw_tom = 1'b0, fim = 1'b0;
  logic [2:0] sw_nota = 3'd0;
  logic       ok, tom, locked;
  logic [2:0] nota, note_cnt;
  logic [6:0] display;
  typedef struct {
    int         due;
    logic [2:0] nota;
    logic       tom;
    logic [2:0] cnt;
    logic [6:0] disp;
  } exp_t;
  exp_t q[$];
  logic [6:0] seg_tab [8] = '{7'b1000000, 7'b0111001, 7'b1011110, 7'b1111001,
                             7'b1110001, 7'b0111101, 7'b1110111, 7'b1111100};
  int cyc = 0, n_cmp = 0, n_bad = 0, mcnt = 0;
  logic ok_prev = 1'b0;
  note_entry_capture #(.DEB_CYCLES(16'd4), .MAX_NOTES(3'd6)) dut (
    .clk(clk), .reset(reset), .btn_ok(btn_ok), .sw_nota(sw_nota), .sw_tom(sw_tom),
    .fim(fim), .ok(ok), .nota(nota), .tom(tom), .note_cnt(note_cnt),
    .locked(locked), .display(display)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask
  task automatic push(input int due, input logic [2:0] n, input logic t);
    mcnt++;
    q.push_back('{due, n, t, 3'(mcnt), seg_tab[n]});
  endtask
  always @(negedge clk) begin
    if (ok === 1'b1) begin
      exp_t e;
      chk("ok_width", int'(ok_prev), 0);
      if (q.size() == 0) chk("unexpected_ok", q.size(), 1);
      else begin
        e = q.pop_front();
        chk("ok_cycle", cyc, e.due);
        chk("nota", int'(nota), int'(e.nota));
        chk("tom", int'(tom), int'(e.tom));
        chk("note_cnt", int'(note_cnt), int'(e.cnt));
        chk("display", int'(display), int'(e.disp));
      end
    end
    ok_prev = ok;
  end
  task automatic check_reset_vals();
    chk("rst_ok", int'(ok), 0);
    chk("rst_nota", int'(nota), 0);
    chk("rst_tom", int'(tom), 0);
    chk("rst_cnt", int'(note_cnt), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_display", int'(display), 0);
  endtask
  task automatic do_reset();
    chk("pending_before_reset", q.size(), 0);
    q.delete();
    @(negedge clk);
    reset = 1'b1; btn_ok = 1'b0; sw_nota = 3'd0; sw_tom = 1'b0; fim = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mcnt = 0;
    check_reset_vals();
  endtask
  task automatic press(input logic [2:0] n, input logic t, input int hold, input bit cap);
    @(negedge clk);
    sw_nota = n; sw_tom = t;
    repeat (3) @(negedge clk);
    btn_ok = 1'b1;
    if (cap) push(cyc + 6, n, t);
    repeat (hold) @(negedge clk);
    btn_ok = 1'b0;
    repeat (12) @(negedge clk);
  endtask
  initial begin
    logic [2:0] seq [6] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b000};
    do_reset();
    // clean long press
    press(3'b110, 1'b0, 20, 1'b1);
    chk("t1_cnt", int'(note_cnt), 1);
    chk("t1_display", int'(display), int'(7'b1110111));
    // bouncing press; only the final rise counts
    @(negedge clk);
    sw_nota = 3'b100; sw_tom = 1'b1;
    repeat (3) @(negedge clk);
    btn_ok = 1'b1; @(negedge clk);
    btn_ok = 1'b0; @(negedge clk);
    btn_ok = 1'b1; @(negedge clk);
    btn_ok = 1'b0; @(negedge clk);
    btn_ok = 1'b1;
    push(cyc + 6, 3'b100, 1'b1);
    repeat (10) @(negedge clk);
    btn_ok = 1'b0;
    repeat (12) @(negedge clk);
    chk("t2_cnt", int'(note_cnt), 2);
    // fill to saturation, then one extra press
    do_reset();
    for (int i = 0; i < 6; i++) press(seq[i], 1'b0, 8, 1'b1);
    chk("t3_cnt", int'(note_cnt), 6);
    chk("t3_locked", int'(locked), 1);
    press(3'b111, 1'b1, 8, 1'b0);
    chk("t3_nota_kept", int'(nota), 0);
    chk("t3_tom_kept", int'(tom), 0);
    chk("t3_cnt_sat", int'(note_cnt), 6);
    chk("t3_display", int'(display), int'(7'b1000000));
    // fim locks entry
    do_reset();
    press(3'b001, 1'b1, 8, 1'b1);
    press(3'b010, 1'b0, 8, 1'b1);
    chk("t4_unlocked", int'(locked), 0);
    @(negedge clk);
    fim = 1'b1;
    @(negedge clk);
    chk("t4_locked", int'(locked), 1);
    fim = 1'b0;
    press(3'b011, 1'b1, 8, 1'b0);
    chk("t4_cnt", int'(note_cnt), 2);
    chk("t4_locked_hold", int'(locked), 1);
    chk("t4_nota_kept", int'(nota), 2);
    // reset mid-debounce with the button held
    do_reset();
    press(3'b011, 1'b1, 8, 1'b1);
    @(negedge clk);
    btn_ok = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_vals();
    @(negedge clk);
    reset = 1'b0;
    mcnt = 0;
    push(cyc + 6, 3'b011, 1'b1);
    repeat (10) @(negedge clk);
    btn_ok = 1'b0;
    repeat (12) @(negedge clk);
    chk("t5_cnt", int'(note_cnt), 1);
    // switch activity without a press
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sw_nota = 3'(i); sw_tom = i[0];
    end
    repeat (5) @(negedge clk);
    chk("t6_nota", int'(nota), 3);
    chk("t6_tom", int'(tom), 1);
    chk("t6_display", int'(display), int'(7'b1111001));
    chk("t6_cnt", int'(note_cnt), 1);
    chk("left_in_queue", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
